mackerel_bus_master: RTL and testbench
======================================

Name: mackerel_bus_master

Overview:
- 68000-style asynchronous bus initiator: takes single read/write commands from an internal requester and runs one bus cycle per command.
- Drives address, function code, AS, UDS/LDS, R/W and write data; waits for DTACK from the responder side (address decoder / peripheral DTACK logic); returns read data or error.
- Intended for a DMA/test master on the Mackerel bus.

Parameters:
- TIMEOUT_CYCLES, 64: WAIT-state cycles without DTACK before a cycle is aborted (used only with BUS_TIMEOUT_EN).
- FC_VALUE, 3'b101: function code driven during every cycle (supervisor data).

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-low
- CMD_VALID  in  1  command request
- CMD_READY  out  1  command accepted when high with CMD_VALID at a rising edge
- CMD_WR  in  1  1=write, 0=read
- CMD_WORD  in  1  1=16-bit access, 0=byte
- CMD_ADDR  in  24  byte address; bit 0 selects byte lane
- CMD_WDATA  in  16  write data (byte writes use the lane selected by bit 0)
- RSP_VALID  out  1  one-cycle response pulse
- RSP_RDATA  out  16  read data, valid with RSP_VALID
- RSP_ERR  out  1  error flag, valid with RSP_VALID
- ADDR  out  23  bus address A23:A1
- FC  out  3  function code
- AS  out  1  address strobe, active-low
- UDS  out  1  upper data strobe, active-low
- LDS  out  1  lower data strobe, active-low
- RW  out  1  1=read, 0=write
- DATA_OUT  out  16  write data to the bus
- DATA_OE  out  1  data bus output enable, active-high
- DATA_IN  in  16  data from the bus
- DTACK  in  1  data acknowledge, active-low, asynchronous

Behaviour:
- Reset (RST low at an edge): state IDLE; AS=UDS=LDS=1; RW=1; DATA_OE=0; RSP_VALID=0; RSP_ERR=0; RSP_RDATA=0; ADDR=0; FC=0; CMD_READY=1 after reset. Reset mid-cycle releases all strobes at that same edge; no response is issued.
- DTACK passes through a 2-flop synchronizer (dtk_s). dtk_s resets to 1 and samples continuously.
- CMD_READY=1 only in IDLE.
- IDLE: on accept, register ADDR=CMD_ADDR[23:1], RW=~CMD_WR, FC=FC_VALUE and the lane mask, then go to ADDR.
  - Lane mask: word gives UDS+LDS; byte with A0=0 gives UDS only; byte with A0=1 gives LDS only.
  - Writes: DATA_OUT=CMD_WDATA. Byte writes replicate the selected byte on both halves.
- IDLE with word access and CMD_ADDR[0]=1: address error. No bus cycle is run. The next cycle gives RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0, and the state stays IDLE.
- ADDR (1 cycle): writes set DATA_OE=1 on entry. At the exit edge: AS=0; reads also assert the lane strobes. Go to STROBE.
- STROBE (1 cycle): writes assert the lane strobes at the exit edge. Go to WAIT.
- WAIT: at the first edge with dtk_s=0:
  - Reads capture DATA_IN into RSP_RDATA. Byte reads zero the unselected byte; lower-lane bytes are returned in RSP_RDATA[7:0].
  - Deassert AS, UDS and LDS; set DATA_OE=0.
  - RSP_VALID=1 and RSP_ERR=0 for the following cycle.
  - Go to RELEASE.
- RELEASE: hold strobes inactive. Go to IDLE at the first edge with dtk_s=1 (responder has removed DTACK).
- Latency with DTACK already low: RSP_VALID is high in the 4th cycle after the accept edge (accept→ADDR→STROBE→WAIT→response).
- RW and ADDR hold their values until the next accept.
- DTACK glitch shorter than one clock may be missed. The spec does not require it to be detected.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined: an internal counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with dtk_s still 1:
  - strobes deassert and DATA_OE=0;
  - RSP_VALID=1, RSP_ERR=1, RSP_RDATA=0;
  - state goes directly to IDLE.
- Defined: RELEASE also exits to IDLE after TIMEOUT_CYCLES cycles of dtk_s=0, with no extra response.
- Undefined: no counter; WAIT and RELEASE wait indefinitely. RSP_ERR is set only by address errors.

Test Plan:
- Word read at 0x3F0000, responder drives DATA_IN=0xBEEF and pulls DTACK low 2 cycles after AS falls, releasing it when AS rises → ADDR=0x1F8000, FC=101, RW=1, UDS=LDS=0 while AS=0; RSP_VALID one cycle with RSP_RDATA=0xBEEF, RSP_ERR=0; CMD_READY returns high after DTACK rises.
- Byte write 0x5A to 0x000003 → RW=0, DATA_OE=1 one cycle before AS=0; LDS=0, UDS=1; DATA_OUT=0x5A5A; DS falls one cycle after AS; RSP_VALID, RSP_ERR=0.
- Word read at odd address 0x000101 → AS never asserts; RSP_VALID next cycle with RSP_ERR=1, RSP_RDATA=0.
- DTACK held low before command, word read → RSP_VALID exactly 4 cycles after the accept edge; CMD_VALID held high during the cycle is not accepted until IDLE.
- RST low while in WAIT → AS=UDS=LDS=1, DATA_OE=0, RSP_VALID=0 after that edge; a new read after reset completes normally.
- BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, DTACK never asserted → strobes release after 8 WAIT cycles; RSP_VALID with RSP_ERR=1; state IDLE, CMD_READY=1.

Source files
------------

// File: rtl/mackerel_bus_master.sv
// 68000-style bus initiator for the Mackerel bus: one AS/DS cycle per command, DTACK-terminated.
// Optional build macro BUS_TIMEOUT_EN adds a WAIT/RELEASE watchdog of TIMEOUT_CYCLES cycles.
module mackerel_bus_master #(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [2:0] FC_VALUE       = 3'b101
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic        CMD_WORD,
  input  logic [23:0] CMD_ADDR,
  input  logic [15:0] CMD_WDATA,
  output logic        RSP_VALID,
  output logic [15:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [22:0] ADDR,
  output logic [2:0]  FC,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [15:0] DATA_IN,
  input  logic        DTACK
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        dtk_p0, dtk_s;
  logic [1:0]  lane;
  logic        accept, addr_err, do_start, do_aerr, do_ack, do_tmo, tmo_hit;

  // {upper, lower} strobe enables for a given access
  function automatic logic [1:0] lane_of(input logic word, input logic a0);
    if (word) return 2'b11;
    return a0 ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [15:0] wr_data(input logic word, input logic a0, input logic [15:0] d);
    if (word) return d;
    return a0 ? {d[7:0], d[7:0]} : {d[15:8], d[15:8]};
  endfunction

  function automatic logic [15:0] rd_mask(input logic [1:0] ln, input logic [15:0] d);
    return d & {{8{ln[1]}}, {8{ln[0]}}};
  endfunction

  assign CMD_READY = (state == S_IDLE);
  assign accept    = CMD_VALID && CMD_READY;
  assign addr_err  = CMD_WORD && CMD_ADDR[0];
  assign do_start  = accept && !addr_err;
  assign do_aerr   = accept && addr_err;
  assign do_ack    = (state == S_WAIT) && !dtk_s;
  assign do_tmo    = (state == S_WAIT) && dtk_s && tmo_hit;

  // DTACK synchronizer stage p0 -> s
  always_ff @(posedge CLK) begin
    if (!RST) begin
      dtk_p0 <= 1'b1;
      dtk_s  <= 1'b1;
    end else begin
      dtk_p0 <= DTACK;
      dtk_s  <= dtk_p0;
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!RST || (state_nxt != state))
      tmo_cnt <= '0;
    else if ((state == S_WAIT) || (state == S_RELEASE))
      tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  // Watchdog absent: never true for any legal TIMEOUT_CYCLES
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (do_start) state_nxt = S_ADDR;
      S_ADDR:    state_nxt = S_STROBE;
      S_STROBE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (!dtk_s)       state_nxt = S_RELEASE;
        else if (tmo_hit) state_nxt = S_IDLE;
      end
      S_RELEASE: if (dtk_s || tmo_hit) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Bus strobes and response registers; strobes released at any reset edge
  always_ff @(posedge CLK) begin
    if (!RST) begin
      AS        <= 1'b1;
      UDS       <= 1'b1;
      LDS       <= 1'b1;
      RW        <= 1'b1;
      DATA_OE   <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
      ADDR      <= '0;
      FC        <= '0;
      lane      <= '0;
    end else begin
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      if (do_start) begin
        ADDR    <= CMD_ADDR[23:1];
        RW      <= ~CMD_WR;
        FC      <= FC_VALUE;
        lane    <= lane_of(CMD_WORD, CMD_ADDR[0]);
        DATA_OE <= CMD_WR;
      end
      if (do_aerr) begin
        RSP_VALID <= 1'b1;
        RSP_ERR   <= 1'b1;
        RSP_RDATA <= '0;
      end
      if (state == S_ADDR) begin
        AS <= 1'b0;
        if (RW) {UDS, LDS} <= ~lane;
      end
      if ((state == S_STROBE) && !RW) {UDS, LDS} <= ~lane;
      if (do_ack || do_tmo) begin
        AS        <= 1'b1;
        UDS       <= 1'b1;
        LDS       <= 1'b1;
        DATA_OE   <= 1'b0;
        RSP_VALID <= 1'b1;
        RSP_ERR   <= do_tmo;
      end
      if (do_ack && RW) RSP_RDATA <= rd_mask(lane, DATA_IN);
      if (do_tmo)       RSP_RDATA <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_start) DATA_OUT <= wr_data(CMD_WORD, CMD_ADDR[0], CMD_WDATA);
  end

endmodule

// File: tb/tb_mackerel_bus_master.sv
// Directed self-checking bench for mackerel_bus_master; covers the timeout build when BUS_TIMEOUT_EN is defined.
module tb_mackerel_bus_master;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CMD_VALID, CMD_READY, CMD_WR, CMD_WORD;
  logic [23:0] CMD_ADDR;
  logic [15:0] CMD_WDATA;
  logic        RSP_VALID, RSP_ERR;
  logic [15:0] RSP_RDATA;
  logic [22:0] ADDR;
  logic [2:0]  FC;
  logic        AS, UDS, LDS, RW, DATA_OE;
  logic [15:0] DATA_OUT, DATA_IN;
  logic        DTACK;

  int n_cmp  = 0;
  int n_fail = 0;

  mackerel_bus_master #(.TIMEOUT_CYCLES(8), .FC_VALUE(3'b101)) dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR), .CMD_WORD(CMD_WORD),
    .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .ADDR(ADDR), .FC(FC), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .DTACK(DTACK)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rsp(input int max, output int n, output bit seen);
    seen = 1'b0;
    n = 0;
    while (!seen && n < max) begin
      tick();
      n++;
      if (RSP_VALID === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_ready(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (CMD_READY === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic issue(input logic wr, input logic word, input logic [23:0] a, input logic [15:0] d);
    CMD_WR = wr; CMD_WORD = word; CMD_ADDR = a; CMD_WDATA = d; CMD_VALID = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b0; CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_WORD = 1'b0;
    CMD_ADDR = '0; CMD_WDATA = '0; DATA_IN = '0; DTACK = 1'b1;
    repeat (3) tick();
    n_cmp++; if ({AS, UDS, LDS, RW} !== 4'b1111) begin n_fail++; $display("FAIL rst_strobes: got %b want 1111", {AS, UDS, LDS, RW}); end
    n_cmp++; if ({DATA_OE, RSP_VALID, RSP_ERR} !== 3'b000) begin n_fail++; $display("FAIL rst_oe_rsp: got %b want 000", {DATA_OE, RSP_VALID, RSP_ERR}); end
    n_cmp++; if ({RSP_RDATA, ADDR, FC} !== 42'd0) begin n_fail++; $display("FAIL rst_regs: got %h/%h/%h want 0", RSP_RDATA, ADDR, FC); end
    RST = 1'b1;
    tick();
    n_cmp++; if (CMD_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", CMD_READY); end
  endtask

  task automatic test_word_read();
    int n; bit seen;
    issue(1'b0, 1'b1, 24'h3F0000, 16'h0000);
    tick();
    CMD_VALID = 1'b0;
    n_cmp++; if ({ADDR, FC, RW, AS, CMD_READY} !== {23'h1F8000, 3'b101, 1'b1, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL rd_setup: got addr=%h fc=%b rw=%b as=%b rdy=%b want 1f8000/101/1/1/0", ADDR, FC, RW, AS, CMD_READY); end
    tick();
    n_cmp++; if ({AS, UDS, LDS} !== 3'b000) begin n_fail++; $display("FAIL rd_strobes: got %b want 000", {AS, UDS, LDS}); end
    tick(); tick();
    DATA_IN = 16'hBEEF; DTACK = 1'b0;
    wait_rsp(10, n, seen);
    n_cmp++; if (!seen || n != 3) begin n_fail++; $display("FAIL rd_latency: got seen=%0d n=%0d want seen=1 n=3", seen, n); end
    n_cmp++; if ({RSP_RDATA, RSP_ERR} !== {16'hBEEF, 1'b0}) begin n_fail++; $display("FAIL rd_data: got %h err=%b want beef err=0", RSP_RDATA, RSP_ERR); end
    n_cmp++; if ({AS, UDS, LDS} !== 3'b111) begin n_fail++; $display("FAIL rd_release: got %b want 111", {AS, UDS, LDS}); end
    DTACK = 1'b1;
    tick();
    n_cmp++; if ({RSP_VALID, CMD_READY} !== 2'b00) begin n_fail++; $display("FAIL rd_pulse: got vld=%b rdy=%b want 0 0", RSP_VALID, CMD_READY); end
    wait_ready(10, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL rd_ready: got 0 want 1"); end
  endtask

  task automatic test_byte_write();
    int n; bit seen;
    issue(1'b1, 1'b0, 24'h000003, 16'h005A);
    tick();
    CMD_VALID = 1'b0;
    n_cmp++; if ({DATA_OE, AS, RW, DATA_OUT, ADDR} !== {1'b1, 1'b1, 1'b0, 16'h5A5A, 23'h000001}) begin
      n_fail++; $display("FAIL wr_setup: got oe=%b as=%b rw=%b dout=%h addr=%h want 1/1/0/5a5a/000001", DATA_OE, AS, RW, DATA_OUT, ADDR); end
    tick();
    n_cmp++; if ({AS, UDS, LDS, DATA_OE} !== 4'b0111) begin n_fail++; $display("FAIL wr_as: got %b want 0111", {AS, UDS, LDS, DATA_OE}); end
    tick();
    n_cmp++; if ({AS, UDS, LDS} !== 3'b010) begin n_fail++; $display("FAIL wr_ds: got %b want 010", {AS, UDS, LDS}); end
    DTACK = 1'b0;
    wait_rsp(10, n, seen);
    n_cmp++; if (!seen || n != 3) begin n_fail++; $display("FAIL wr_latency: got seen=%0d n=%0d want seen=1 n=3", seen, n); end
    n_cmp++; if ({RSP_ERR, DATA_OE, AS, UDS, LDS} !== 5'b00111) begin n_fail++; $display("FAIL wr_end: got %b want 00111", {RSP_ERR, DATA_OE, AS, UDS, LDS}); end
    DTACK = 1'b1;
    wait_ready(10, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL wr_ready: got 0 want 1"); end
  endtask

  task automatic test_addr_error();
    bit as_ok;
    issue(1'b0, 1'b1, 24'h000101, 16'h0000);
    tick();
    CMD_VALID = 1'b0;
    n_cmp++; if ({RSP_VALID, RSP_ERR, RSP_RDATA, AS, CMD_READY} !== {1'b1, 1'b1, 16'h0000, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL aerr_rsp: got vld=%b err=%b rd=%h as=%b rdy=%b want 1/1/0000/1/1", RSP_VALID, RSP_ERR, RSP_RDATA, AS, CMD_READY); end
    tick();
    n_cmp++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL aerr_pulse: got %b want 0", RSP_VALID); end
    as_ok = 1'b1;
    repeat (4) begin tick(); if (AS !== 1'b1) as_ok = 1'b0; end
    n_cmp++; if (!as_ok) begin n_fail++; $display("FAIL aerr_no_as: got 0 want 1"); end
  endtask

  task automatic test_back_to_back();
    int first; int n; bit seen; bit hold_ok;
    DTACK = 1'b0;
    repeat (3) tick();
    DATA_IN = 16'h1234;
    issue(1'b0, 1'b1, 24'h000010, 16'h0000);
    first = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (first == 0 && RSP_VALID === 1'b1) first = i;
    end
    n_cmp++; if (first != 4) begin n_fail++; $display("FAIL b2b_latency: got %0d want 4", first); end
    n_cmp++; if (RSP_RDATA !== 16'h1234) begin n_fail++; $display("FAIL b2b_data: got %h want 1234", RSP_RDATA); end
    hold_ok = 1'b1;
    repeat (2) begin tick(); if (CMD_READY !== 1'b0 || AS !== 1'b1) hold_ok = 1'b0; end
    n_cmp++; if (!hold_ok) begin n_fail++; $display("FAIL b2b_hold: got accepted-early want held"); end
    DATA_IN = 16'h4321; DTACK = 1'b1;
    wait_ready(10, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL b2b_ready: got 0 want 1"); end
    tick();
    n_cmp++; if ({CMD_READY, ADDR} !== {1'b0, 23'h000008}) begin n_fail++; $display("FAIL b2b_accept: got rdy=%b addr=%h want 0/000008", CMD_READY, ADDR); end
    CMD_VALID = 1'b0; DTACK = 1'b0;
    wait_rsp(10, n, seen);
    n_cmp++; if (!seen || RSP_RDATA !== 16'h4321) begin n_fail++; $display("FAIL b2b_second: got seen=%0d rd=%h want 1/4321", seen, RSP_RDATA); end
    DTACK = 1'b1;
    wait_ready(10, seen);
  endtask

  task automatic test_reset_mid_cycle();
    int n; bit seen;
    issue(1'b1, 1'b1, 24'h000020, 16'h1357);
    tick();
    CMD_VALID = 1'b0;
    repeat (3) tick();
    n_cmp++; if ({AS, UDS, LDS, DATA_OE} !== 4'b0001) begin n_fail++; $display("FAIL mid_active: got %b want 0001", {AS, UDS, LDS, DATA_OE}); end
    RST = 1'b0;
    tick();
    n_cmp++; if ({AS, UDS, LDS, DATA_OE, RSP_VALID, CMD_READY} !== 6'b111001) begin
      n_fail++; $display("FAIL mid_reset: got %b want 111001", {AS, UDS, LDS, DATA_OE, RSP_VALID, CMD_READY}); end
    RST = 1'b1;
    tick();
    DATA_IN = 16'hA5C3; DTACK = 1'b0;
    issue(1'b0, 1'b1, 24'h000040, 16'h0000);
    tick();
    CMD_VALID = 1'b0;
    wait_rsp(10, n, seen);
    n_cmp++; if (!seen || {RSP_RDATA, RSP_ERR} !== {16'hA5C3, 1'b0}) begin n_fail++; $display("FAIL mid_after: got seen=%0d rd=%h err=%b want 1/a5c3/0", seen, RSP_RDATA, RSP_ERR); end
    DTACK = 1'b1;
    wait_ready(10, seen);
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL mid_ready: got 0 want 1"); end
  endtask

  task automatic test_timeout();
    int n; bit seen;
    DTACK = 1'b1;
    issue(1'b0, 1'b1, 24'h000080, 16'h0000);
    tick();
    CMD_VALID = 1'b0;
    tick(); tick();
`ifdef BUS_TIMEOUT_EN
    wait_rsp(20, n, seen);
    n_cmp++; if (!seen || n != 8) begin n_fail++; $display("FAIL tmo_latency: got seen=%0d n=%0d want 1/8", seen, n); end
    n_cmp++; if ({RSP_ERR, RSP_RDATA, AS, UDS, LDS, DATA_OE, CMD_READY} !== {1'b1, 16'h0000, 3'b111, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL tmo_rsp: got err=%b rd=%h strb=%b oe=%b rdy=%b want 1/0000/111/0/1", RSP_ERR, RSP_RDATA, {AS, UDS, LDS}, DATA_OE, CMD_READY); end
`else
    wait_rsp(30, n, seen);
    n_cmp++; if (seen || AS !== 1'b0) begin n_fail++; $display("FAIL notmo_wait: got seen=%0d as=%b want 0/0", seen, AS); end
    DTACK = 1'b0;
    wait_rsp(10, n, seen);
    n_cmp++; if (!seen || RSP_ERR !== 1'b0) begin n_fail++; $display("FAIL notmo_done: got seen=%0d err=%b want 1/0", seen, RSP_ERR); end
    DTACK = 1'b1;
    wait_ready(10, seen);
`endif
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_byte_write();
    test_addr_error();
    test_back_to_back();
    test_reset_mid_cycle();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
